// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared state encoding and constants for the instruction fetch unit
//   IDLE/REQ/HOLD/DISCARD fetch states, default reset PC, sequential PC step, NOP encoding
package if_fetch_unit_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, DISCARD = 2'd3} fetch_state_e;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP  = 32'd4;
   localparam logic [31:0] NOP          = 32'h0000_0013;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC holder, imem req/ack fetcher, one-entry stall buffer and redirect handling
//   clk_i/rst_i                 clock, async active-low reset
//   start_i                     run enable
//   stall_i/mem_stall_i         pipeline stalls (either one blocks delivery)
//   branch_*/jump_*             ID-stage redirects, branch wins
//   imem_req_o/addr_o/ack_i/data_i  instruction memory handshake
//   inst_o/pc_o/send_o/flush_o  IF/ID register data, load enable and flush
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        mem_stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        send_o,
   output logic        flush_o
);
   fetch_state_e r_state;
   logic [31:0]  r_pc, r_addr, r_hold_inst, r_hold_pc;
   logic         w_redirect, w_stall;
   logic [31:0]  w_target, w_pc_seq;
   always_comb begin
      w_redirect = (r_state != IDLE) && (branch_i || jump_i);
      w_target   = branch_i ? branch_target_i : jump_target_i;
      w_stall    = stall_i || mem_stall_i;
      w_pc_seq   = r_pc + PC_STEP;
   end
   // req decoded from the state register so reset drops it without waiting for a clock
   assign imem_req_o  = (r_state == REQ) || (r_state == DISCARD);
   assign imem_addr_o = r_addr;
   assign flush_o     = w_redirect;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_pc        <= RESET_PC;
         r_addr      <= RESET_PC;
         r_hold_inst <= '0;
         r_hold_pc   <= '0;
         inst_o      <= '0;
         pc_o        <= '0;
         send_o      <= 1'b0;
      end else begin
         send_o <= 1'b0;
         case (r_state)
            IDLE: if (start_i) begin
               r_addr  <= r_pc;
               r_state <= REQ;
            end
            REQ: if (w_redirect) begin
               // an unacked request must keep its address, so it is drained in DISCARD
               r_pc <= w_target;
               if (imem_ack_i) r_addr <= w_target;
               else r_state <= DISCARD;
            end else if (imem_ack_i) begin
               r_pc <= w_pc_seq;
               if (w_stall) begin
                  r_hold_inst <= imem_data_i;
                  r_hold_pc   <= r_addr;
                  r_state     <= HOLD;
               end else begin
                  inst_o  <= imem_data_i;
                  pc_o    <= r_addr;
                  send_o  <= 1'b1;
                  r_addr  <= w_pc_seq;
                  r_state <= start_i ? REQ : IDLE;
               end
            end
            HOLD: if (w_redirect) begin
               r_pc    <= w_target;
               r_addr  <= w_target;
               r_state <= REQ;
            end else if (!w_stall) begin
               inst_o  <= r_hold_inst;
               pc_o    <= r_hold_pc;
               send_o  <= 1'b1;
               r_addr  <= r_pc;
               r_state <= start_i ? REQ : IDLE;
            end
            DISCARD: if (w_redirect) begin
               // an ack coinciding with a new redirect ends the stale request right away
               r_pc <= w_target;
               if (imem_ack_i) begin
                  r_addr  <= w_target;
                  r_state <= REQ;
               end
            end else if (imem_ack_i) begin
               r_addr  <= r_pc;
               r_state <= REQ;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that produces the instruction/PC pair consumed by the IF/ID pipeline register. It holds the PC and runs a req/ack handshake to instruction memory, which may return data after a variable number of wait cycles. It also buffers one fetched instruction while the pipeline is stalled and applies branch/jump redirects. It drives the IF/ID register's send (load-enable) and flush inputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  run enable; fetching begins when high
stall_i  input  1  hazard-detect stall (load-use)
mem_stall_i  input  1  data-cache stall, whole pipeline frozen
branch_i  input  1  taken branch resolved in ID, single-cycle pulse
branch_target_i  input  32  branch target
jump_i  input  1  jump decoded in ID, single-cycle pulse
jump_target_i  input  32  jump target
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  fetch address, stable while req high and no ack
imem_ack_i  input  1  data valid this cycle; ends the request
imem_data_i  input  32  fetched instruction
inst_o  output  32  instruction to IF/ID
pc_o  output  32  address of inst_o
send_o  output  1  one-cycle pulse; IF/ID loads inst_o/pc_o
flush_o  output  1  IF/ID flush

Behaviour:
- Reset (rst_i low, async): pc_r=RESET_PC, addr_r=RESET_PC, state IDLE. imem_req_o, send_o, flush_o are 0. inst_o=0, pc_o=0, hold buffer=0.
- States: IDLE, REQ, HOLD, DISCARD. imem_req_o=1 in REQ and DISCARD only. imem_addr_o=addr_r.
- IDLE: if start_i=1, set addr_r<=pc_r and go to REQ. Otherwise stay.
- REQ: wait for imem_ack_i, with req and addr held stable.
  - On ack with no redirect and no stall (stall_i|mem_stall_i=0): inst_o<=imem_data_i, pc_o<=addr_r, send_o<=1 for the next cycle, pc_r<=pc_r+PC_STEP. Next fetch starts with addr_r<=pc_r+PC_STEP. Stay in REQ if start_i=1, else go to IDLE.
  - On ack while stalled: latch the data and addr_r into the hold buffer, pc_r<=pc_r+PC_STEP, go to HOLD.
- Back-to-back acks sustain one instruction per cycle. Fetch latency from request to send_o is ack wait + 1 cycle.
- HOLD: imem_req_o=0, send_o=0. In the first cycle with stall_i|mem_stall_i=0, present the buffer (send_o=1 next cycle), load addr_r<=pc_r, and go to REQ (IDLE if start_i=0).
- send_o is 0 in every cycle not listed above. inst_o/pc_o hold their values while send_o=0.
- Redirect (branch_i|jump_i in REQ, HOLD or DISCARD; ignored in IDLE):
  - branch_i has priority over jump_i.
  - flush_o=branch_i|jump_i, combinational, same cycle.
  - pc_r<=target.
  - HOLD buffer discarded, no send.
  - Redirect overrides any stall in the same cycle.
- Redirect in REQ without ack: go to DISCARD. The old request continues, since addr must stay stable.
- Redirect in REQ with ack in the same cycle: data dropped. addr_r<=target, stay in REQ.
- Redirect in HOLD: addr_r<=target, go to REQ.
- DISCARD: wait for ack and drop the data, send_o=0. Then addr_r<=pc_r, go to REQ. A further redirect in DISCARD updates pc_r and stays in DISCARD.
- start_i falling mid-request: the outstanding request completes normally (delivered or held), then the block goes to IDLE.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Async reset mid-request: the request is abandoned immediately and imem_req_o drops asynchronously.

Decomposition:
- Shared package: state encoding (IDLE/REQ/HOLD/DISCARD, 2 bits), RESET_PC default, PC_STEP, 32-bit NOP constant.
- No sub-module needed. The next-PC mux (branch/jump/sequential) stays inline as a combinational block.

Test Plan:
- Reset, then start_i=1 with ack same cycle as req, data 0x11,0x22,0x33 → send_o high on consecutive cycles; pc_o = 0x0, 0x4, 0x8; inst_o matches.
- Ack delayed 3 cycles per fetch → imem_addr_o stable during the wait; send_o pulses once per fetch, 4 cycles apart.
- stall_i=1 for 4 cycles as ack for addr 0x8 arrives → no send, no new req; one cycle after release, send_o=1 with pc_o=0x8; next req addr=0xC.
- branch_i=1 with target 0x100 while the request for 0x10 waits for ack → flush_o=1 that cycle; the 0x10 data is dropped; next request addr=0x100 and the first send has pc_o=0x100.
- branch_i and jump_i together (0x200 vs 0x300) in the same cycle as an ack → data dropped; next addr=0x200.
- rst_i low mid-wait, then high → all outputs 0; first request at RESET_PC after start_i.
